// File: rtl/peripheral_register_controller.sv
// Bus-to-counter-core register bridge: COUNT / CONFIG / STATUS registers behind a
// three-phase (IDLE, ACCESS, ACK) request/acknowledge handshake, with a latched lt_1k interrupt.
module peripheral_register_controller #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    output logic              bus_err,
    output logic [31:0]       count_in,
    output logic              count_en_in,
    output logic              count_dir_in,
    output logic              count_ire_in,
    output logic              count_we,
    output logic              count_config_we,
    input  logic [31:0]       count_out,
    input  logic              count_en_out,
    input  logic              count_dir_out,
    input  logic              count_ire_out,
    input  logic              count_lt_1k_out,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [1:0] A_COUNT  = 2'd0;
    localparam logic [1:0] A_CONFIG = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_UNMAP  = 2'd3;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [1:0]  r_addr;
    logic        r_w1c;
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_count_in;
    logic        r_en_in;
    logic        r_dir_in;
    logic        r_ire_in;
    logic        r_count_we;
    logic        r_config_we;
    logic        r_irq_pending;
    logic        r_lt_prev;

    logic        w_start;
    logic [1:0]  w_dec;
    logic        w_irq_set;
    logic        w_irq_clr;
    logic        w_unused_addr;

    assign w_dec         = bus_addr[3:2];
    assign w_unused_addr = &{1'b0, bus_addr};
    assign w_start       = (r_state == IDLE) && bus_req;
    assign w_irq_set     = count_lt_1k_out && !r_lt_prev && count_ire_out;
    assign w_irq_clr     = (r_state == ACCESS) && r_we && (r_addr == A_STATUS) && r_w1c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus_req) w_next = ACCESS;
            ACCESS:  w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Core strobes and data are registered on entry to ACCESS so they are live exactly during ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_w1c         <= 1'b0;
            r_rdata       <= '0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_count_in    <= '0;
            r_en_in       <= 1'b0;
            r_dir_in      <= 1'b0;
            r_ire_in      <= 1'b0;
            r_count_we    <= 1'b0;
            r_config_we   <= 1'b0;
            r_irq_pending <= 1'b0;
            r_lt_prev     <= 1'b0;
        end else begin
            r_count_we  <= 1'b0;
            r_config_we <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;

            if (w_start) begin
                r_we   <= bus_we;
                r_addr <= w_dec;
                r_w1c  <= bus_wdata[0];
                if (bus_we && (w_dec == A_COUNT)) begin
                    r_count_in <= bus_wdata;
                    r_count_we <= 1'b1;
                end
                if (bus_we && (w_dec == A_CONFIG)) begin
                    r_en_in     <= bus_wdata[0];
                    r_dir_in    <= bus_wdata[1];
                    r_ire_in    <= bus_wdata[2];
                    r_config_we <= 1'b1;
                end
            end

            if (r_state == ACCESS) begin
                r_ack <= 1'b1;
                r_err <= (r_addr == A_UNMAP);
                if (!r_we) begin
                    case (r_addr)
                        A_COUNT:  r_rdata <= count_out;
                        A_CONFIG: r_rdata <= {28'b0, count_lt_1k_out, count_ire_out,
                                              count_dir_out, count_en_out};
                        A_STATUS: r_rdata <= {31'b0, r_irq_pending};
                        default:  r_rdata <= '0;
                    endcase
                end
            end

            // A set event in the same cycle as a W1C clear leaves the bit set.
            r_irq_pending <= w_irq_set || (r_irq_pending && !w_irq_clr);
            r_lt_prev     <= count_lt_1k_out;
        end
    end

    assign bus_rdata       = r_rdata;
    assign bus_ack         = r_ack;
    assign bus_err         = r_err;
    assign count_in        = r_count_in;
    assign count_en_in     = r_en_in;
    assign count_dir_in    = r_dir_in;
    assign count_ire_in    = r_ire_in;
    assign count_we        = r_count_we;
    assign count_config_we = r_config_we;
    assign irq             = r_irq_pending;

endmodule

// File: tb/tb_peripheral_register_controller.sv
// Directed bench for peripheral_register_controller: bus transactions with a read-data/err
// scoreboard, strobe timing, interrupt set/clear/mask behaviour and mid-transaction reset.
module tb_peripheral_register_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] count_in;
    logic        count_en_in;
    logic        count_dir_in;
    logic        count_ire_in;
    logic        count_we;
    logic        count_config_we;
    logic [31:0] count_out;
    logic        count_en_out;
    logic        count_dir_out;
    logic        count_ire_out;
    logic        count_lt_1k_out;
    logic        irq;

    int n_run  = 0;
    int n_fail = 0;
    logic [32:0] sb[$];

    peripheral_register_controller #(.ADDR_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .bus_ack         (bus_ack),
        .bus_err         (bus_err),
        .count_in        (count_in),
        .count_en_in     (count_en_in),
        .count_dir_in    (count_dir_in),
        .count_ire_in    (count_ire_in),
        .count_we        (count_we),
        .count_config_we (count_config_we),
        .count_out       (count_out),
        .count_en_out    (count_en_out),
        .count_dir_out   (count_dir_out),
        .count_ire_out   (count_ire_out),
        .count_lt_1k_out (count_lt_1k_out),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; rise_in_access raises count_lt_1k_out during the ACCESS cycle.
    task automatic xfer(input string tag, input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input logic exp_cwe, input logic exp_cfgwe, input logic rise_in_access);
        int cyc;
        logic [32:0] e;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        sb.push_back({exp_err, exp_rd});
        cycle();
        chk({tag, "_count_we"}, 32'(count_we), 32'(exp_cwe));
        chk({tag, "_config_we"}, 32'(count_config_we), 32'(exp_cfgwe));
        chk({tag, "_ack_early"}, 32'(bus_ack), 32'd0);
        if (exp_cwe) chk({tag, "_count_in"}, count_in, wd);
        if (rise_in_access) begin
            @(negedge clk);
            count_lt_1k_out = 1'b1;
        end
        cyc = 0;
        do begin
            cycle();
            cyc++;
        end while (!bus_ack && cyc < 4);
        chk({tag, "_ack_latency"}, 32'(cyc), 32'd1);
        chk({tag, "_ack_seen"}, 32'(bus_ack), 32'd1);
        chk({tag, "_strobes_off"}, 32'({count_we, count_config_we}), 32'd0);
        e = sb.pop_front();
        chk({tag, "_rdata"}, bus_rdata, e[31:0]);
        chk({tag, "_err"}, 32'(bus_err), 32'(e[32]));
        @(negedge clk);
        bus_req = 1'b0;
        cycle();
        chk({tag, "_ack_pulse"}, 32'(bus_ack), 32'd0);
        chk({tag, "_rdata_idle"}, bus_rdata, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        count_out = '0; count_en_out = 1'b0; count_dir_out = 1'b0;
        count_ire_out = 1'b0; count_lt_1k_out = 1'b0;
        #1;
        chk("rst_ack", 32'(bus_ack), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_strobes", 32'({count_we, count_config_we, bus_err}), 32'd0);
        chk("rst_cfg_in", 32'({count_en_in, count_dir_in, count_ire_in}), 32'd0);
        chk("rst_count_in", count_in, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        xfer("wr_count", 1'b1, 4'h0, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("count_in_hold", count_in, 32'h0000_1234);

        xfer("wr_config", 1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cfg_in_bits", 32'({count_ire_in, count_dir_in, count_en_in}), 32'd7);
        chk("count_in_after_cfg", count_in, 32'h0000_1234);

        count_en_out = 1'b1; count_dir_out = 1'b1; count_ire_out = 1'b1; count_lt_1k_out = 1'b0;
        xfer("rd_config", 1'b0, 4'h4, 32'h0, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);

        count_en_out = 1'b0; count_dir_out = 1'b1; count_ire_out = 1'b0;
        xfer("rd_config_alias", 1'b0, 4'h5, 32'h0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);

        count_out = 32'hDEAD_BEEF;
        xfer("rd_count", 1'b0, 4'h3, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);

        xfer("rd_unmapped", 1'b0, 4'hC, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer("wr_unmapped", 1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("unmapped_no_change", count_in, 32'h0000_1234);
        chk("unmapped_cfg_hold", 32'({count_ire_in, count_dir_in, count_en_in}), 32'd7);

        // Masked rising edge
        @(negedge clk); count_ire_out = 1'b0; count_lt_1k_out = 1'b1;
        cycle(); cycle();
        chk("irq_masked", 32'(irq), 32'd0);

        @(negedge clk); count_lt_1k_out = 1'b0; count_ire_out = 1'b1;
        cycle();
        @(negedge clk); count_lt_1k_out = 1'b1;
        cycle();
        chk("irq_set", 32'(irq), 32'd1);

        @(negedge clk); count_ire_out = 1'b0;
        cycle(); cycle();
        chk("irq_mask_keeps", 32'(irq), 32'd1);

        xfer("rd_status", 1'b0, 4'h8, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer("wr_status0", 1'b1, 4'h8, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("irq_w0_keeps", 32'(irq), 32'd1);
        xfer("wr_status1", 1'b1, 4'h8, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("irq_cleared", 32'(irq), 32'd0);
        xfer("rd_status0", 1'b0, 4'h8, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk); count_lt_1k_out = 1'b0; count_ire_out = 1'b1;
        cycle();
        @(negedge clk); count_lt_1k_out = 1'b1;
        cycle();
        chk("irq_set2", 32'(irq), 32'd1);
        @(negedge clk); count_lt_1k_out = 1'b0;
        cycle();
        xfer("w1c_vs_set", 1'b1, 4'h8, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("irq_set_wins", 32'(irq), 32'd1);

        // Reset during ACCESS of a COUNT write
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'hCAFE_0001;
        cycle();
        chk("abort_we_pre", 32'(count_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_we", 32'(count_we), 32'd0);
        chk("abort_count_in", count_in, 32'd0);
        chk("abort_irq", 32'(irq), 32'd0);
        chk("abort_outs", 32'({bus_ack, bus_err, count_config_we, count_en_in,
                               count_dir_in, count_ire_in}), 32'd0);
        chk("abort_rdata", bus_rdata, 32'd0);
        bus_req = 1'b0;
        cycle();
        chk("abort_no_ack_rst", 32'(bus_ack), 32'd0);
        @(negedge clk); reset = 1'b0;
        cycle(); cycle();
        chk("abort_no_ack", 32'({bus_ack, count_we}), 32'd0);

        xfer("post_rst_wr", 1'b1, 4'h0, 32'h0000_00AB, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_register_controller.md
PERIPHERAL_REGISTER_CONTROLLER -- requirements
Module: peripheral_register_controller

Interface
REQ-001 Parameter ADDR_W, default 4, bus byte-address width; only bits [3:2] decode, other bits ignored.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 bus_req  input  1  request; held high by requester until bus_ack.
REQ-005 bus_we  input  1  1=write, 0=read; sampled with bus_req.
REQ-006 bus_addr  input  ADDR_W  byte address; 0x0 COUNT, 0x4 CONFIG, 0x8 STATUS.
REQ-007 bus_wdata  input  32  write data.
REQ-008 bus_rdata  output  32  read data; valid only while bus_ack=1, else 0.
REQ-009 bus_ack  output  1  one-cycle completion pulse.
REQ-010 bus_err  output  1  asserted with bus_ack for an unmapped address (0xC).
REQ-011 count_in / count_en_in / count_dir_in / count_ire_in  output  32/1/1/1  registered write data to counter core.
REQ-012 count_we, count_config_we  output  1 each  one-cycle write strobes to counter core.
REQ-013 count_out / count_en_out / count_dir_out / count_ire_out / count_lt_1k_out  input  32/1/1/1/1  counter core state.
REQ-014 irq  output  1  level interrupt = irq_pending.

Function
REQ-015 FSM states IDLE, ACCESS, ACK; IDLE->ACCESS when bus_req=1; ACCESS->ACK unconditionally; ACK->IDLE unconditionally.
REQ-016 On IDLE->ACCESS, latch bus_we, bus_addr, bus_wdata; bus inputs ignored outside IDLE.
REQ-017 Latency: bus_req first sampled in cycle N -> strobe/sample in cycle N+1 (ACCESS) -> bus_ack in cycle N+2; one transaction per 3 cycles max.
REQ-018 Requester keeping bus_req high after bus_ack starts a new transaction on the following IDLE cycle.
REQ-019 Write COUNT: in ACCESS, count_in=wdata and count_we=1 for exactly one cycle.
REQ-020 Write CONFIG: in ACCESS, count_en_in=wdata[0], count_dir_in=wdata[1], count_ire_in=wdata[2], count_config_we=1 for one cycle; wdata[31:3] ignored.
REQ-021 Write STATUS: wdata[0]=1 clears irq_pending (write-1-to-clear); no core strobe.
REQ-022 count_in and config *_in outputs hold last written value between writes.
REQ-023 Read: in ACCESS, capture COUNT=count_out; CONFIG={28'b0, count_lt_1k_out, count_ire_out, count_dir_out, count_en_out}; STATUS={31'b0, irq_pending}; present on bus_rdata during ACK.
REQ-024 Unmapped address: no strobe, no state change, bus_rdata=0, bus_err=1 with bus_ack.
REQ-025 irq_pending sets on a cycle where count_lt_1k_out rises (registered previous value 0, current 1) and count_ire_out=1.
REQ-026 Simultaneous set event and W1C clear in the same cycle: set wins, irq_pending=1.
REQ-027 count_ire_out=0 masks new set events but does not clear an existing pending bit.

Reset
REQ-028 On reset assertion, immediately: state=IDLE, bus_ack=0, bus_err=0, bus_rdata=0, count_we=0, count_config_we=0, count_in=0, count_en_in=0, count_dir_in=0, count_ire_in=0, irq_pending=0, irq=0, lt_1k previous-value register=0.
REQ-029 Reset mid-transaction aborts it: no ack and no strobe is issued for the aborted request; requester must re-issue.
REQ-030 After reset release, first bus_req sampled is handled per REQ-017.

Verification
REQ-031 Write COUNT 0x0000_1234 -> count_we=1 one cycle at N+1 with count_in=0x1234; bus_ack at N+2, bus_err=0.
REQ-032 Write CONFIG 0xFFFF_FFFF then read CONFIG with core echoing en/dir/ire=1, lt_1k=0 -> count_config_we pulse, read returns 0x0000_0007.
REQ-033 ire=1, count_lt_1k_out 0->1 -> irq=1 next cycle; read STATUS returns 0x1; write STATUS 0x1 -> irq=0 after ACCESS cycle.
REQ-034 lt_1k rising edge in same cycle as STATUS W1C ACCESS -> irq stays 1.
REQ-035 Read address 0xC -> bus_ack=1, bus_err=1, bus_rdata=0, no strobes.
REQ-036 Assert reset during ACCESS of a COUNT write -> count_we low immediately, no bus_ack, all outputs at REQ-028 values.
